axi_mmio_console: RTL

AXI_MMIO_CONSOLE -- requirements
Module: axi_mmio_console

---
 rtl/axi_mmio_console.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/axi_mmio_console.sv
// AXI4-Lite MMIO console: byte pushes to CON_ADDR drain through a TX FIFO,
// a sticky pass/fail test register, and a STATUS word at CON_ADDR+4.
module axi_mmio_console #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] CON_ADDR   = 32'h1000_0000,
    parameter logic [31:0] TEST_ADDR  = 32'h2000_0000,
    parameter logic [31:0] PASS_CODE  = 32'd123456789
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tests_passed,
    output logic        tests_failed
);
    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [31:0] STAT_ADDR = CON_ADDR + 32'd4;
    localparam logic [1:0]  OKAY      = 2'b00;
    localparam logic [1:0]  SLVERR    = 2'b10;

    logic             alive;
    logic             aw_latched, w_latched, w_strb0;
    logic [31:0]      aw_addr, w_data;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, empty, stall, commit, push, pop;
    logic             aw_hs, w_hs, ar_hs;
    logic             unused_strb;

    assign unused_strb = ^s_wstrb[3:1];

    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign empty  = (count == '0);
    // A TXDATA write waits while the FIFO is full, judged on the registered count.
    assign stall  = (aw_addr == CON_ADDR) && full;
    assign commit = aw_latched && w_latched && !stall;
    assign push   = commit && (aw_addr == CON_ADDR) && w_strb0;
    assign pop    = tx_valid && tx_ready;

    assign tx_valid = !empty;
    assign tx_data  = tx_valid ? mem[rd_ptr] : 8'h00;

    // alive holds the readies low for one cycle after reset is released.
    assign s_awready = alive && !aw_latched && !s_bvalid;
    assign s_wready  = alive && !w_latched && !s_bvalid;
    assign s_arready = alive && !s_rvalid;
    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid && s_wready;
    assign ar_hs     = s_arvalid && s_arready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= w_data[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alive        <= 1'b0;
            aw_latched   <= 1'b0;
            w_latched    <= 1'b0;
            aw_addr      <= '0;
            w_data       <= '0;
            w_strb0      <= 1'b0;
            s_bvalid     <= 1'b0;
            s_bresp      <= OKAY;
            tests_passed <= 1'b0;
            tests_failed <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
        end else begin
            alive <= 1'b1;
            if (aw_hs) begin
                aw_latched <= 1'b1;
                aw_addr    <= s_awaddr;
            end
            if (w_hs) begin
                w_latched <= 1'b1;
                w_data    <= s_wdata;
                w_strb0   <= s_wstrb[0];
            end
            if (commit) begin
                aw_latched <= 1'b0;
                w_latched  <= 1'b0;
                s_bvalid   <= 1'b1;
                if (aw_addr == CON_ADDR) begin
                    s_bresp <= OKAY;
                end else if (aw_addr == TEST_ADDR) begin
                    s_bresp <= OKAY;
                    if (!tests_passed && !tests_failed) begin
                        if (w_data == PASS_CODE) tests_passed <= 1'b1;
                        else                     tests_failed <= 1'b1;
                    end
                end else begin
                    s_bresp <= SLVERR;
                end
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= OKAY;
        end else if (ar_hs) begin
            s_rvalid <= 1'b1;
            if (s_araddr == STAT_ADDR) begin
                s_rdata <= {20'b0, tests_failed, tests_passed, full, empty, 1'b0, 7'(count)};
                s_rresp <= OKAY;
            end else if (s_araddr == TEST_ADDR) begin
                s_rdata <= {30'b0, tests_failed, tests_passed};
                s_rresp <= OKAY;
            end else begin
                s_rdata <= 32'hDEAD_BEEF;
                s_rresp <= SLVERR;
            end
        end else if (s_rvalid && s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

endmodule
